pwm_cfg_ctrl: RTL and testbench

Configuration sequencer that sits between the register/bus side and the PWM generator. It accepts a complete PWM configuration through a valid/ready handshake and validates it. It holds the configuration in shadow registers and commits it atomically to the generator's config inputs at a counter wrap boundary, so a period is never produced with mixed old and new settings. It reports commit, rejection, abort and timeout status as single-cycle pulses.

---
 rtl/pwm_cfg_ctrl_if.sv | 23 ++
 rtl/pwm_cfg_ctrl.sv | 131 +++++++++++++
 tb/tb_pwm_cfg_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_cfg_ctrl_if.sv
// Configuration request bundle: valid/ready handshake plus the full PWM setting.
// Master offers cfg_valid with fields; slave returns cfg_ready.
interface pwm_cfg_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_en;
    logic [CNT_W-1:0] cfg_period;
    logic [7:0]       cfg_functions;
    logic [CNT_W-1:0] cfg_compare1;
    logic [CNT_W-1:0] cfg_compare2;

    modport master (
        output cfg_valid, cfg_en, cfg_period, cfg_functions, cfg_compare1, cfg_compare2,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_en, cfg_period, cfg_functions, cfg_compare1, cfg_compare2,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_cfg_ctrl.sv
// Validates a PWM config and commits it atomically on a counter wrap (2 cycles when disabled, else on wrap/timeout).
// Backpressure: cfg_ready is high only in IDLE; offers made while busy are ignored.
module pwm_cfg_ctrl #(
    parameter int TIMEOUT = 131072,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    pwm_cfg_ctrl_if.slave    cfg_if,
    input  logic             cfg_abort,
    input  logic [CNT_W-1:0] count_val,
    output logic             pwm_en,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       functions,
    output logic [CNT_W-1:0] compare1,
    output logic [CNT_W-1:0] compare2,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             cfg_aborted,
    output logic             cfg_timeout
);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PEND} state_t;

    state_t            r_state;
    logic              r_sh_en;
    logic [CNT_W-1:0]  r_sh_period, r_sh_cmp1, r_sh_cmp2;
    logic [7:0]        r_sh_func;
    logic [CNT_W-1:0]  r_prev_count;
    logic [WAIT_W-1:0] r_wait;
    logic              r_pwm_en;
    logic [CNT_W-1:0]  r_period, r_cmp1, r_cmp2;
    logic [7:0]        r_func;
    logic              r_done, r_err, r_aborted, r_timeout;

    logic w_wrap, w_cfg_ok, w_timeout_hit, w_free_commit;

    // A wrap is judged against the period currently driving the generator.
    assign w_wrap = ((r_prev_count == r_period) && (count_val == '0)) ||
                    ((r_prev_count == '0) && (count_val == r_period));
    assign w_cfg_ok = (r_sh_period != '0) && (r_sh_cmp1 <= r_sh_period) &&
                      (!r_sh_func[1] || ((r_sh_cmp1 < r_sh_cmp2) && (r_sh_cmp2 <= r_sh_period)));
    assign w_timeout_hit = (TIMEOUT != 0) && (r_wait == WAIT_LAST);
    assign w_free_commit = !r_pwm_en || w_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sh_en      <= 1'b0;
            r_sh_period  <= '0;
            r_sh_cmp1    <= '0;
            r_sh_cmp2    <= '0;
            r_sh_func    <= '0;
            r_prev_count <= '0;
            r_wait       <= '0;
            r_pwm_en     <= 1'b0;
            r_period     <= '0;
            r_cmp1       <= '0;
            r_cmp2       <= '0;
            r_func       <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_aborted    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_aborted    <= 1'b0;
            r_timeout    <= 1'b0;
            r_prev_count <= count_val;
            case (r_state)
                S_IDLE: begin
                    if (cfg_if.cfg_valid) begin
                        r_sh_en     <= cfg_if.cfg_en;
                        r_sh_period <= cfg_if.cfg_period;
                        r_sh_func   <= cfg_if.cfg_functions;
                        r_sh_cmp1   <= cfg_if.cfg_compare1;
                        r_sh_cmp2   <= cfg_if.cfg_compare2;
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_cfg_ok) begin
                        r_state <= S_PEND;
                        r_wait  <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end
                end
                S_PEND: begin
                    if (cfg_abort) begin
                        r_state     <= S_IDLE;
                        r_aborted   <= 1'b1;
                        r_sh_en     <= 1'b0;
                        r_sh_period <= '0;
                        r_sh_func   <= '0;
                        r_sh_cmp1   <= '0;
                        r_sh_cmp2   <= '0;
                    end else if (w_free_commit || w_timeout_hit) begin
                        // All five fields move together so no period mixes old and new settings.
                        r_pwm_en  <= r_sh_en;
                        r_period  <= r_sh_period;
                        r_func    <= r_sh_func;
                        r_cmp1    <= r_sh_cmp1;
                        r_cmp2    <= r_sh_cmp2;
                        r_done    <= 1'b1;
                        r_timeout <= !w_free_commit;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_if.cfg_ready = (r_state == S_IDLE);
    assign pwm_en      = r_pwm_en;
    assign period      = r_period;
    assign functions   = r_func;
    assign compare1    = r_cmp1;
    assign compare2    = r_cmp2;
    assign cfg_done    = r_done;
    assign cfg_err     = r_err;
    assign cfg_aborted = r_aborted;
    assign cfg_timeout = r_timeout;
endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Directed bench for pwm_cfg_ctrl: transaction-level model checked every cycle plus literal latency/value checks.
`timescale 1ns/1ps
module tb_pwm_cfg_ctrl;
    localparam int CNT_W = 16;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_abort;
    logic [CNT_W-1:0] count_val;
    logic             pwm_en;
    logic [CNT_W-1:0] period, compare1, compare2;
    logic [7:0]       functions;
    logic             cfg_done, cfg_err, cfg_aborted, cfg_timeout;

    pwm_cfg_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    pwm_cfg_ctrl #(.TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_if(cfg_if), .cfg_abort(cfg_abort), .count_val(count_val),
        .pwm_en(pwm_en), .period(period), .functions(functions), .compare1(compare1),
        .compare2(compare2), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .cfg_aborted(cfg_aborted), .cfg_timeout(cfg_timeout)
    );

    always #5 clk = ~clk;

    // Stand-in for the counter block: hold, count up to cnt_top, or load a value.
    logic             cnt_up, cnt_ld;
    logic [CNT_W-1:0] cnt_ld_val, cnt_top;
    always @(posedge clk) begin
        if (cnt_ld) count_val <= cnt_ld_val;
        else if (cnt_up) count_val <= (count_val >= cnt_top) ? '0 : count_val + 1'b1;
    end

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic             en;
        logic [CNT_W-1:0] per;
        logic [7:0]       fn;
        logic [CNT_W-1:0] c1;
        logic [CNT_W-1:0] c2;
    } cfg_t;

    function automatic bit cfg_ok(input cfg_t c);
        if (c.per == 0) return 0;
        if (c.c1 > c.per) return 0;
        if (c.fn[1] && !(c.c1 < c.c2 && c.c2 <= c.per)) return 0;
        return 1;
    endfunction

    // Model: a pending request ages one step per cycle; age 0 is the check cycle,
    // age k>=1 means k-1 cycles already waited for a wrap.
    cfg_t             m_act, m_sh;
    bit               m_busy, m_done, m_err, m_abt, m_to;
    int               m_age;
    logic [CNT_W-1:0] m_prev;

    always @(posedge clk) begin : model
        bit wrap;
        wrap = (m_prev == m_act.per && count_val == 0) || (m_prev == 0 && count_val == m_act.per);
        m_done = 0; m_err = 0; m_abt = 0; m_to = 0;
        if (rst) begin
            m_act = '0; m_sh = '0; m_busy = 0; m_age = 0; m_prev = '0;
        end else begin
            if (!m_busy) begin
                if (cfg_if.cfg_valid) begin
                    m_sh = '{en: cfg_if.cfg_en, per: cfg_if.cfg_period, fn: cfg_if.cfg_functions,
                             c1: cfg_if.cfg_compare1, c2: cfg_if.cfg_compare2};
                    m_busy = 1; m_age = 0;
                end
            end else if (m_age == 0) begin
                if (cfg_ok(m_sh)) m_age = 1;
                else begin m_busy = 0; m_err = 1; end
            end else if (cfg_abort) begin
                m_busy = 0; m_abt = 1;
            end else if (!m_act.en || wrap) begin
                m_act = m_sh; m_done = 1; m_busy = 0;
            end else if (TMO != 0 && m_age == TMO) begin
                m_act = m_sh; m_done = 1; m_to = 1; m_busy = 0;
            end else begin
                m_age++;
            end
            m_prev = count_val;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cfg_ready", cfg_if.cfg_ready, !m_busy);
            check("pwm_en", pwm_en, m_act.en);
            check("period", period, m_act.per);
            check("functions", functions, m_act.fn);
            check("compare1", compare1, m_act.c1);
            check("compare2", compare2, m_act.c2);
            check("cfg_done", cfg_done, m_done);
            check("cfg_err", cfg_err, m_err);
            check("cfg_aborted", cfg_aborted, m_abt);
            check("cfg_timeout", cfg_timeout, m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic en, input logic [CNT_W-1:0] per, input logic [CNT_W-1:0] c1,
                        input logic [CNT_W-1:0] c2, input logic [7:0] fn);
        int g = 0;
        while (cfg_if.cfg_ready !== 1'b1 && g < 50) begin tick(); g++; end
        check("send_ready", cfg_if.cfg_ready, 1);
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_en        = en;
        cfg_if.cfg_period    = per;
        cfg_if.cfg_compare1  = c1;
        cfg_if.cfg_compare2  = c2;
        cfg_if.cfg_functions = fn;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Counts edges until a status pulse is visible; returns at the negedge showing it.
    task automatic wait_evt(input int maxc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!(cfg_done || cfg_err || cfg_aborted) && n < maxc);
    endtask

    int n;

    initial begin
        rst = 1'b1; cfg_abort = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_en = 1'b0; cfg_if.cfg_period = '0;
        cfg_if.cfg_compare1 = '0; cfg_if.cfg_compare2 = '0; cfg_if.cfg_functions = '0;
        cnt_up = 1'b0; cnt_ld = 1'b1; cnt_ld_val = '0; cnt_top = 16'd10;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0; cnt_ld = 1'b0;
        @(negedge clk);
        check("rst_ready", cfg_if.cfg_ready, 1);
        check("rst_pwm_en", pwm_en, 0);
        check("rst_period", period, 0);

        // Disabled generator: commit two edges after transfer.
        send(1, 100, 40, 0, 8'h00);
        wait_evt(20, n);
        check("dis_latency", n, 2);
        check("dis_done", cfg_done, 1);
        check("dis_period", period, 100);
        check("dis_cmp1", compare1, 40);
        check("dis_en", pwm_en, 1);
        @(negedge clk);
        check("dis_done_pulse", cfg_done, 0);
        check("dis_ready_after", cfg_if.cfg_ready, 1);

        // Frozen counter, enabled: forced commit after 8 waiting cycles.
        cnt_ld = 1'b1; cnt_ld_val = 16'd5; tick(); cnt_ld = 1'b0;
        send(1, 10, 4, 0, 8'h00);
        wait_evt(30, n);
        check("to_latency", n, 9);
        check("to_done", cfg_done, 1);
        check("to_flag", cfg_timeout, 1);
        check("to_period", period, 10);

        // Running counter, period 10: commit on the 10 -> 0 wrap.
        cnt_top = 16'd10; cnt_up = 1'b1; cnt_ld = 1'b1; cnt_ld_val = 16'd3; tick(); cnt_ld = 1'b0;
        send(1, 20, 5, 0, 8'h00);
        wait_evt(30, n);
        check("wrap_latency", n, 8);
        check("wrap_count", count_val, 1);
        check("wrap_no_to", cfg_timeout, 0);
        check("wrap_period", period, 20);
        cnt_up = 1'b0;

        // Rejected configurations leave the active set untouched.
        send(1, 50, 30, 30, 8'h02);
        wait_evt(10, n);
        check("err1_latency", n, 1);
        check("err1_flag", cfg_err, 1);
        check("err1_period", period, 20);
        send(1, 0, 0, 0, 8'h00);
        wait_evt(10, n);
        check("err2_flag", cfg_err, 1);
        send(1, 50, 60, 0, 8'h00);
        wait_evt(10, n);
        check("err3_flag", cfg_err, 1);
        check("err3_done", cfg_done, 0);
        check("err3_cmp1", compare1, 5);

        // Abort in the same cycle a wrap is seen.
        cnt_ld = 1'b1; cnt_ld_val = 16'd7; tick(); cnt_ld = 1'b0;
        send(1, 30, 3, 0, 8'h00);
        tick(); cnt_ld = 1'b1; cnt_ld_val = 16'd20;
        tick(); cnt_ld_val = 16'd0;
        tick(); cnt_ld = 1'b0; cfg_abort = 1'b1;
        tick(); cfg_abort = 1'b0;
        @(negedge clk);
        check("abt_flag", cfg_aborted, 1);
        check("abt_done", cfg_done, 0);
        check("abt_period", period, 20);

        // Abort while idle does nothing.
        tick(); cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
        @(negedge clk);
        check("abt_idle", cfg_aborted, 0);

        // Down-count wrap (0 -> period); compare1 equal to period is legal.
        send(1, 25, 25, 0, 8'h00);
        tick(); cnt_ld = 1'b1; cnt_ld_val = 16'd20;
        wait_evt(20, n);
        cnt_ld = 1'b0;
        check("down_latency", n, 2);
        check("down_done", cfg_done, 1);
        check("down_period", period, 25);
        check("down_cmp1", compare1, 25);

        // Reset while pending discards everything.
        send(1, 40, 10, 0, 8'h00);
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        check("prst_en", pwm_en, 0);
        check("prst_period", period, 0);
        check("prst_ready", cfg_if.cfg_ready, 1);
        cnt_ld = 1'b1; cnt_ld_val = 16'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("prst_no_done", cfg_done, 0);
        end
        cnt_ld = 1'b0;

        // Unaligned mode with compare2 at the period boundary.
        send(1, 50, 10, 50, 8'h03);
        wait_evt(20, n);
        check("unal_latency", n, 2);
        check("unal_func", functions, 3);
        check("unal_cmp2", compare2, 50);

        // Disable request while enabled waits for a wrap; frozen counter forces the timeout.
        send(0, 50, 10, 50, 8'h03);
        wait_evt(30, n);
        check("off_latency", n, 9);
        check("off_en", pwm_en, 0);
        check("off_to", cfg_timeout, 1);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
